// File: rtl/led_pulse_driver.sv
// rtl/led_pulse_driver.sv - turns single-cycle event pulses into visible LED blinks
//
// Purpose:
//   Every accepted event becomes one blink. A blink is ON_CYCLES cycles of
//   led_out high followed by a forced OFF_CYCLES low gap. Events that arrive
//   while a blink is in progress are queued in a saturating pending counter.
//   When the gap ends and an event is waiting, the next blink starts with no
//   idle cycle in between.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   pulse_in  in   event strobe; each cycle sampled high is one event
//   led_out   out  registered LED drive, high during the ON phase
//   busy      out  registered, high during ON or GAP
//   pending   out  registered count of queued blinks not yet started
//   overflow  out  sticky event-dropped flag (only with LED_PULSE_OVERFLOW_FLAG_EN)
//
// Configuration:
//   LED_PULSE_OVERFLOW_FLAG_EN - when defined, adds the overflow port and its
//   sticky flag register. Drop behaviour at saturation is the same either way.

module led_pulse_driver #(
  parameter int ON_CYCLES   = 5000000,
  parameter int OFF_CYCLES  = 5000000,
  parameter int MAX_PENDING = 7,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pulse_in,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending
`ifdef LED_PULSE_OVERFLOW_FLAG_EN
  ,
  output logic              overflow
`endif
);

  // The phase counter must hold the larger of the two phase lengths minus one.
  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_n;
  logic               led_n;
  logic               busy_n;
  logic [PEND_W-1:0]  pend_n;

  logic pend_nz;
  logic pend_full;
  logic cnt_zero;
  logic gap_end;

  assign pend_nz   = (pending != '0);
  assign pend_full = (pending == PEND_MAX);
  assign cnt_zero  = (cnt == '0);
  // Final cycle of the gap: a new blink may be launched here.
  assign gap_end   = (state == S_GAP) && cnt_zero;

  // Next-state and registered-output logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    led_n   = led_out;
    busy_n  = busy;
    pend_n  = pending;

    case (state)
      S_IDLE: begin
        led_n  = 1'b0;
        busy_n = 1'b0;
        // pending is normally zero here; a nonzero count is serviced as an
        // event so a queued blink can never be stranded.
        if (pulse_in || pend_nz) begin
          state_n = S_ON;
          cnt_n   = ON_LOAD;
          led_n   = 1'b1;
          busy_n  = 1'b1;
          if (pend_nz && !pulse_in) begin
            pend_n = pending - PEND_ONE;
          end
        end
      end

      S_ON: begin
        led_n  = 1'b1;
        busy_n = 1'b1;
        if (cnt_zero) begin
          state_n = S_GAP;
          cnt_n   = OFF_LOAD;
          led_n   = 1'b0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
        if (pulse_in && !pend_full) begin
          pend_n = pending + PEND_ONE;
        end
      end

      S_GAP: begin
        led_n  = 1'b0;
        busy_n = 1'b1;
        if (cnt_zero) begin
          if (pend_nz || pulse_in) begin
            // Back-to-back blink. A simultaneous new pulse replaces the
            // consumed entry (or starts the blink itself when nothing is
            // queued), so pending only drops when no pulse arrives.
            state_n = S_ON;
            cnt_n   = ON_LOAD;
            led_n   = 1'b1;
            if (pend_nz && !pulse_in) begin
              pend_n = pending - PEND_ONE;
            end
          end else begin
            state_n = S_IDLE;
            busy_n  = 1'b0;
          end
        end else begin
          cnt_n = cnt - 1'b1;
          if (pulse_in && !pend_full) begin
            pend_n = pending + PEND_ONE;
          end
        end
      end

      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        led_n   = 1'b0;
        busy_n  = 1'b0;
        pend_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      led_out <= 1'b0;
      busy    <= 1'b0;
      pending <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      led_out <= led_n;
      busy    <= busy_n;
      pending <= pend_n;
    end
  end

`ifdef LED_PULSE_OVERFLOW_FLAG_EN
  // An event is lost only when the queue is full and it is not absorbed by
  // the gap-end launch, which frees a slot in the same cycle.
  logic drop;
  assign drop = busy && pulse_in && pend_full && !gap_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_led_pulse_driver.sv
// tb/tb_led_pulse_driver.sv - self-checking bench for led_pulse_driver
module tb_led_pulse_driver;

  localparam int ON_C  = 4;
  localparam int OFF_C = 3;
  localparam int MAXP  = 2;
  localparam int PW    = 2;

  logic          clk;
  logic          reset;
  logic          pulse_in;
  logic          led_out;
  logic          busy;
  logic [PW-1:0] pending;
`ifdef LED_PULSE_OVERFLOW_FLAG_EN
  logic          overflow;
`endif

  int tests;
  int fails;

  // Reference model: elapsed time since the current blink started.
  int m_busy;
  int m_t;
  int m_pend;
`ifdef LED_PULSE_OVERFLOW_FLAG_EN
  int m_ovf;
`endif

  led_pulse_driver #(
    .ON_CYCLES  (ON_C),
    .OFF_CYCLES (OFF_C),
    .MAX_PENDING(MAXP),
    .PEND_W     (PW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pulse_in(pulse_in),
    .led_out (led_out),
    .busy    (busy),
    .pending (pending)
`ifdef LED_PULSE_OVERFLOW_FLAG_EN
    ,
    .overflow(overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_t    = 0;
    m_pend = 0;
`ifdef LED_PULSE_OVERFLOW_FLAG_EN
    m_ovf  = 0;
`endif
  endtask

  // One clock edge of the reference: a blink occupies ON_C+OFF_C cycles,
  // led is high for the first ON_C of them.
  task automatic model_edge(input int p);
    if (m_busy == 0) begin
      if (p != 0 || m_pend > 0) begin
        m_busy = 1;
        m_t    = 0;
        if (m_pend > 0 && p == 0) m_pend--;
      end
    end else begin
      m_t++;
      if (m_t == ON_C + OFF_C) begin
        m_t = 0;
        if (m_pend > 0 || p != 0) begin
          if (m_pend > 0 && p == 0) m_pend--;
        end else begin
          m_busy = 0;
        end
      end else if (p != 0) begin
        if (m_pend < MAXP) m_pend++;
`ifdef LED_PULSE_OVERFLOW_FLAG_EN
        else m_ovf = 1;
`endif
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".led"}, 32'(led_out), 32'((m_busy != 0 && m_t < ON_C) ? 1 : 0));
    check({tag, ".busy"}, 32'(busy), 32'(m_busy));
    check({tag, ".pending"}, 32'(pending), 32'(m_pend));
`ifdef LED_PULSE_OVERFLOW_FLAG_EN
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
`endif
  endtask

  // Drive one cycle of stimulus, advance model on the edge, sample after it.
  task automatic step(input int p, input string tag);
    @(negedge clk);
    pulse_in = (p != 0);
    @(posedge clk);
    model_edge(p);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    pulse_in = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    reset    = 1'b1;
    pulse_in = 1'b0;
    model_reset();
    #12;
    check("reset.led", 32'(led_out), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.pending", 32'(pending), 32'd0);
    do_reset();

    for (int i = 0; i < 5; i++) step(0, "idle");

    // Single pulse: 4 high, 3 low, then idle.
    step(1, "single");
    check("single.led_rise", 32'(led_out), 32'd1);
    for (int i = 0; i < 8; i++) step(0, "single");
    check("single.idle_busy", 32'(busy), 32'd0);

    // Three pulses during ON saturate the queue; three blinks follow.
    step(1, "burst");
    for (int i = 0; i < 3; i++) step(1, "burst");
    check("burst.pend_sat", 32'(pending), 32'(MAXP));
    for (int i = 0; i < 3 * (ON_C + OFF_C) + 2; i++) step(0, "burst");

    // pending=1 with a pulse on the final gap cycle.
    step(1, "gapend_p1");
    step(1, "gapend_p1");
    for (int i = 0; i < ON_C + OFF_C - 2; i++) step(0, "gapend_p1");
    step(1, "gapend_p1");
    check("gapend_p1.pend_kept", 32'(pending), 32'd1);
    for (int i = 0; i < 3 * (ON_C + OFF_C); i++) step(0, "gapend_p1");

    // pending=0 with a pulse on the final gap cycle.
    step(1, "gapend_p0");
    for (int i = 0; i < ON_C + OFF_C - 1; i++) step(0, "gapend_p0");
    step(1, "gapend_p0");
    check("gapend_p0.busy_held", 32'(busy), 32'd1);
    check("gapend_p0.pend_zero", 32'(pending), 32'd0);
    for (int i = 0; i < ON_C + OFF_C + 2; i++) step(0, "gapend_p0");

    // Asynchronous reset mid-ON with pending full.
    step(1, "midreset");
    step(1, "midreset");
    step(1, "midreset");
    reset = 1'b1;
    #1;
    check("midreset.led", 32'(led_out), 32'd0);
    check("midreset.busy", 32'(busy), 32'd0);
    check("midreset.pending", 32'(pending), 32'd0);
`ifdef LED_PULSE_OVERFLOW_FLAG_EN
    check("midreset.overflow", 32'(overflow), 32'd0);
`endif
    pulse_in = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(1, "postreset");
    for (int i = 0; i < ON_C + OFF_C + 2; i++) step(0, "postreset");

    // Randomized traffic with varying event density.
    for (int blk = 0; blk < 12; blk++) begin
      int dens;
      case (blk % 4)
        0: dens = 3;
        1: dens = 15;
        2: dens = 45;
        default: dens = 90;
      endcase
      if (blk == 6) do_reset();
      for (int i = 0; i < 200; i++) begin
        step(($urandom_range(0, 99) < dens) ? 1 : 0, "random");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
